// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one 64-bit ALU between two issue ports.
// Operands are held on the ALU for an op-dependent count so MUL/DIV can be multicycle.
module alu_arbiter #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic [3:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic [3:0]  req1_ctrl,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [63:0] resp_result,
  output logic        resp_zero,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [63:0] alu_result,
  input  logic        alu_zero,
  output logic        busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0001;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   a_q, a_d;
  logic [63:0]   b_q, b_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [63:0]   res_q, res_d;
  logic          zero_q, zero_d;

  logic          grant;
  logic          idle;
  logic          hs;
  logic [63:0]   sel_a;
  logic [63:0]   sel_b;
  logic [3:0]    sel_ctrl;
  logic [CW-1:0] sel_cnt;
  logic          div_by_zero;

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req0_valid && !req1_valid): grant = 1'b0;
      (!req0_valid && req1_valid): grant = 1'b1;
      (req0_valid && req1_valid):  grant = ~last_q;
      default:                     grant = 1'b0;
    endcase
  end

  assign idle       = (state_q == S_IDLE);
  assign req0_ready = rst_n & idle & req0_valid & ~grant;
  assign req1_ready = rst_n & idle & req1_valid & grant;
  assign hs         = req0_ready | req1_ready;

  assign sel_a    = grant ? req1_a    : req0_a;
  assign sel_b    = grant ? req1_b    : req0_b;
  assign sel_ctrl = grant ? req1_ctrl : req0_ctrl;

  // Counter is loaded with lat-1 so it reaches zero on the last EXEC cycle.
  always_comb begin
    sel_cnt = '0;
    unique case (1'b1)
      (sel_ctrl == OP_MUL): sel_cnt = CW'(MUL_LAT - 1);
      (sel_ctrl == OP_DIV): sel_cnt = CW'(DIV_LAT - 1);
      default:              sel_cnt = '0;
    endcase
  end

  assign div_by_zero = (ctrl_q == OP_DIV) && (b_q == 64'd0);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          a_d     = sel_a;
          b_d     = sel_b;
          ctrl_d  = sel_ctrl;
          owner_d = grant;
          last_d  = grant;
          cnt_d   = sel_cnt;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          res_d   = div_by_zero ? {64{1'b1}} : alu_result;
          zero_d  = div_by_zero ? 1'b0 : alu_zero;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_ctrl    = ctrl_q;
  assign resp_result = res_q;
  assign resp_zero   = zero_q;
  assign resp0_valid = (state_q == S_RESP) & ~owner_q;
  assign resp1_valid = (state_q == S_RESP) & owner_q;
  assign busy        = ~idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter against a cycle-timeline reference model.
// A behavioural ALU closes the loop on alu_a/alu_b/alu_ctrl.
module tb_alu_arbiter;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [63:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [3:0]  c0 = '0, c1 = '0;

  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid;
  logic [63:0] resp_result;
  logic        resp_zero;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic        busy;

  always #5 clk = ~clk;

  alu_arbiter #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(req0_ready),
    .req0_a(a0), .req0_b(b0), .req0_ctrl(c0),
    .req1_valid(v1), .req1_ready(req1_ready),
    .req1_a(a1), .req1_b(b1), .req1_ctrl(c1),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  function automatic logic [63:0] alu_fn(logic [63:0] a, logic [63:0] b,
                                         logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b0011: return a * b;
      4'b0001: return (b == 0) ? 64'hDEAD_BEEF : a / b;
      default: return 64'd0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
    alu_zero   = (alu_result == 64'd0);
  end

  function automatic int lat_of(logic [3:0] c);
    if (c == 4'b0011) return MUL_LAT;
    if (c == 4'b0001) return DIV_LAT;
    return 1;
  endfunction

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model: timeline of when the block is free and when the response lands.
  int          idle_from;
  int          resp_cyc;
  logic        last;
  logic        resp_port;
  logic [63:0] m_a, m_b, m_res, pend_res;
  logic [3:0]  m_c;
  logic        m_z, pend_z;
  bit          rnd = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    idle_from = 0;
    resp_cyc  = -1;
    last      = 1'b1;
    resp_port = 1'b0;
    m_a = '0; m_b = '0; m_c = '0;
    m_res = '0; m_z = 1'b0;
    pend_res = '0; pend_z = 1'b0;
  endtask

  task automatic new_op(output logic [63:0] a, output logic [63:0] b,
                        output logic [3:0] c);
    logic [3:0] ops [8];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0110, 4'b0111, 4'b0100, 4'b1111};
    c = ops[$urandom_range(0, 7)];
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) b = a;
    if (c == 4'b0001 && $urandom_range(0, 3) == 0) b = '0;
    if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 20));
  endtask

  task automatic step();
    logic w, e0, e1, rn;
    int   l;
    @(negedge clk);
    w  = (v0 && v1) ? ~last : v1;
    e0 = rst_n && (cyc >= idle_from) && v0 && !w;
    e1 = rst_n && (cyc >= idle_from) && v1 && w;
    rn = (cyc == resp_cyc);
    if (rn) begin
      m_res = pend_res;
      m_z   = pend_z;
    end
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("busy", busy, cyc < idle_from);
    chk("resp0_valid", resp0_valid, rn && !resp_port);
    chk("resp1_valid", resp1_valid, rn && resp_port);
    chk("resp_result", resp_result, m_res);
    chk("resp_zero", resp_zero, m_z);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_ctrl", alu_ctrl, m_c);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (e0 || e1) begin
      m_a = e1 ? a1 : a0;
      m_b = e1 ? b1 : b0;
      m_c = e1 ? c1 : c0;
      last = e1;
      resp_port = e1;
      l = lat_of(m_c);
      resp_cyc  = cyc + l + 1;
      idle_from = cyc + l + 2;
      if (m_c == 4'b0001 && m_b == 0) pend_res = '1;
      else pend_res = alu_fn(m_a, m_b, m_c);
      pend_z = (pend_res == 0);
    end
    cyc++;
    #1;
    if (e0) v0 = 1'b0;
    if (e1) v1 = 1'b0;
    if (rnd) begin
      if (!v0 && $urandom_range(0, 2) == 0) begin
        new_op(a0, b0, c0);
        v0 = 1'b1;
      end
      if (!v1 && $urandom_range(0, 2) == 0) begin
        new_op(a1, b1, c1);
        v1 = 1'b1;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && !(cyc >= idle_from && !v0 && !v1); i++)
      step();
    step();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    v0 = 1; a0 = 64'd1;  b0 = 64'd2;  c0 = 4'b0010;
    v1 = 1; a1 = 64'd10; b1 = 64'd20; c1 = 4'b0010;
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (!v0) begin
        v0 = 1; a0 = 64'($urandom_range(0, 999)); b0 = 64'd3; c0 = 4'b0010;
      end
      if (!v1) begin
        v1 = 1; a1 = 64'($urandom_range(0, 999)); b1 = 64'd4; c1 = 4'b0010;
      end
    end
    drain();

    v0 = 1; a0 = 64'd5; b0 = 64'd7; c0 = 4'b0010;
    drain();

    v1 = 1; a1 = 64'd3; b1 = 64'd4; c1 = 4'b0011;
    repeat (2) step();
    v0 = 1; a0 = 64'd1; b0 = 64'd1; c0 = 4'b0110;
    drain();

    v0 = 1; a0 = 64'd9; b0 = 64'd0; c0 = 4'b0001;
    drain();
    v1 = 1; a1 = 64'h10; b1 = 64'h10; c1 = 4'b0110;
    drain();
    v0 = 1; a0 = 64'd77; b0 = 64'd2; c0 = 4'b1111;
    drain();

    v1 = 1; a1 = 64'd100; b1 = 64'd7; c1 = 4'b0001;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    v0 = 1; a0 = 64'd40; b0 = 64'd2; c0 = 4'b0010;
    drain();

    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1;
    rnd = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
